// File: rtl/bcd_counter_mod10.sv
// rtl/bcd_counter_mod10.sv - single BCD down-counter digit with clear, load, enable and borrow.
// Optional feature macro: BCD_LOAD_CLAMP_EN (clamp out-of-range loads to MODULUS-1).
module bcd_counter_mod10 #(
    parameter int unsigned MODULUS = 10
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       loadn,
    input  logic       en,
    input  logic [3:0] data,
    output logic [3:0] out,
    output logic       tc
);

    localparam logic [3:0] LP_MAX = 4'(MODULUS - 1);
    localparam logic [3:0] LP_MOD = 4'(MODULUS);

    logic [3:0] r_out;
    logic [3:0] w_load_val;
    logic [3:0] w_dec_val;

    always_comb begin
        w_load_val = data;
`ifdef BCD_LOAD_CLAMP_EN
        if (data >= LP_MOD) begin
            w_load_val = LP_MAX;
        end
`else
        // Out-of-range loads are kept verbatim and simply count down to 0.
        if (data >= LP_MOD) begin
            w_load_val = data;
        end
`endif
    end

    always_comb begin
        w_dec_val = (r_out == 4'd0) ? LP_MAX : (r_out - 4'd1);
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            r_out <= 4'd0;
        end else if (!loadn) begin
            r_out <= w_load_val;
        end else if (en) begin
            r_out <= w_dec_val;
        end
    end

    // Borrow into the next digit: asserted on the edge where this digit wraps.
    assign tc  = en & clrn & (r_out == 4'd0);
    assign out = r_out;

endmodule

// File: tb/tb_bcd_counter_mod10.sv
// tb/tb_bcd_counter_mod10.sv - scoreboard bench for bcd_counter_mod10 (MODULUS 10 and 6).
module tb_bcd_counter_mod10;

    logic       clk = 1'b0;
    logic       clrn;
    logic       loadn;
    logic       en;
    logic [3:0] data;
    logic [3:0] out10;
    logic       tc10;
    logic [3:0] out6;
    logic       tc6;

    int n_checks = 0;
    int n_errors = 0;

    logic [3:0] exp_q[$];

    always #5 clk = ~clk;

    bcd_counter_mod10 #(.MODULUS(10)) u_dut10 (
        .clk(clk), .clrn(clrn), .loadn(loadn), .en(en), .data(data),
        .out(out10), .tc(tc10)
    );

    bcd_counter_mod10 #(.MODULUS(6)) u_dut6 (
        .clk(clk), .clrn(clrn), .loadn(loadn), .en(en), .data(data),
        .out(out6), .tc(tc6)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Drive one cycle of controls; check tc before the edge, out after it.
    task automatic step(input string tag, input int sel,
                        input logic c, input logic l, input logic e, input logic [3:0] d,
                        input logic exp_tc, input logic [3:0] exp_next);
        logic [3:0] want;
        @(negedge clk);
        clrn  = c;
        loadn = l;
        en    = e;
        data  = d;
        #1;
        chk({tag, ".tc"}, int'(sel == 6 ? tc6 : tc10), int'(exp_tc));
        exp_q.push_back(exp_next);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk({tag, ".queue"}, 0, 1);
        end else begin
            want = exp_q.pop_front();
            chk({tag, ".out"}, int'(sel == 6 ? out6 : out10), int'(want));
        end
    endtask

    initial begin
        int seq10 [11];
        int seq6  [8];
        seq10 = '{5, 4, 3, 2, 1, 0, 9, 8, 7, 6, 5};
        seq6  = '{0, 5, 4, 3, 2, 1, 0, 5};
        clrn = 1'b0; loadn = 1'b1; en = 1'b0; data = 4'd0;

        step("t1_clr_a", 10, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0);
        step("t1_clr_b", 10, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0);

        step("t2_load4", 10, 1'b1, 1'b0, 1'b0, 4'd4, 1'b0, 4'd4);
        step("t2_dec3",  10, 1'b1, 1'b1, 1'b1, 4'd0, 1'b0, 4'd3);
        step("t2_dec2",  10, 1'b1, 1'b1, 1'b1, 4'd0, 1'b0, 4'd2);
        step("t2_hold",  10, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 4'd2);

        step("t3_midclr", 10, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 4'd0);
        step("t3_load5",  10, 1'b1, 1'b0, 1'b0, 4'd5, 1'b0, 4'd5);
        for (int i = 0; i < 10; i++) begin
            step($sformatf("t3_run%0d", i), 10, 1'b1, 1'b1, 1'b1, 4'd0,
                 (seq10[i] == 0), 4'(seq10[i+1]));
        end

        step("t4_clr_dom",  10, 1'b0, 1'b0, 1'b1, 4'd7, 1'b0, 4'd0);
        step("t4_load_dom", 10, 1'b1, 1'b0, 1'b1, 4'd7, 1'b1, 4'd7);

        step("t5_load0", 6, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
        for (int i = 0; i < 7; i++) begin
            step($sformatf("t5_run%0d", i), 6, 1'b1, 1'b1, 1'b1, 4'd0,
                 (seq6[i] == 0), 4'(seq6[i+1]));
        end

`ifdef BCD_LOAD_CLAMP_EN
        step("t6_loadC", 10, 1'b1, 1'b0, 1'b0, 4'hC, 1'b0, 4'd9);
        step("t6_dec",   10, 1'b1, 1'b1, 1'b1, 4'd0, 1'b0, 4'd8);
        step("t6_loadC6", 6, 1'b1, 1'b0, 1'b0, 4'hC, 1'b0, 4'd5);
`else
        step("t6_loadC", 10, 1'b1, 1'b0, 1'b0, 4'hC, 1'b0, 4'd12);
        step("t6_dec",   10, 1'b1, 1'b1, 1'b1, 4'd0, 1'b0, 4'd11);
        step("t6_loadC6", 6, 1'b1, 1'b0, 1'b0, 4'hC, 1'b0, 4'd12);
`endif
        step("t6_hold",  10, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 4'(out10));
        step("t7_load1", 10, 1'b1, 1'b0, 1'b0, 4'd1, 1'b0, 4'd1);
        step("t7_dec0",  10, 1'b1, 1'b1, 1'b1, 4'd0, 1'b0, 4'd0);
        step("t7_tc_en0", 10, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0);
        step("t7_tc_clr", 10, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 4'd0);

        chk("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
